led_pattern_player: RTL and testbench

LED_PATTERN_PLAYER -- requirements
Module: led_pattern_player

---
 rtl/led_pattern_player.sv | 139 +++++++++++++
 tb/tb_led_pattern_player.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/led_pattern_player.sv
// LED pattern sequencer: steps through a small pattern RAM once every TICK_DIV clocks,
// in loop, one-shot, ping-pong or reverse-loop order.
module led_pattern_player #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 32,
    parameter int TICK_DIV = 2**22,
    localparam int AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic             stop,
    input  logic             hold,
    input  logic [1:0]       mode,
    input  logic [AW-1:0]    last_idx,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] led,
    output logic [AW-1:0]    idx,
    output logic             busy,
    output logic             done
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
    localparam logic [AW-1:0] MAX_IDX   = AW'(DEPTH - 1);

    localparam logic [1:0] M_LOOP = 2'd0;
    localparam logic [1:0] M_ONE  = 2'd1;
    localparam logic [1:0] M_PING = 2'd2;
    localparam logic [1:0] M_REV  = 2'd3;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t          state;
    logic [1:0]      mode_q;
    logic [AW-1:0]   last_q;
    logic [PW-1:0]   presc;
    logic            dir;          // 0 = counting up, 1 = counting down
    logic [AW-1:0]   last_clamp;
    logic [AW-1:0]   nxt_idx;
    logic            nxt_dir;
    logic            finish;

    logic [WIDTH-1:0] mem [DEPTH];

    // Not reset: pattern contents survive resetn.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    assign last_clamp = (last_idx > MAX_IDX) ? MAX_IDX : last_idx;

    always_comb begin
        nxt_idx = idx;
        nxt_dir = dir;
        finish  = 1'b0;
        case (mode_q)
            M_LOOP: nxt_idx = (idx == last_q) ? '0 : idx + AW'(1);
            M_ONE: begin
                if (idx == last_q) finish = 1'b1;
                else               nxt_idx = idx + AW'(1);
            end
            M_PING: begin
                if (last_q == '0) begin
                    nxt_idx = '0;
                end else if (!dir) begin
                    if (idx == last_q) begin
                        nxt_dir = 1'b1;
                        nxt_idx = last_q - AW'(1);
                    end else begin
                        nxt_idx = idx + AW'(1);
                    end
                end else begin
                    if (idx == '0) begin
                        nxt_dir = 1'b0;
                        nxt_idx = AW'(1);
                    end else begin
                        nxt_idx = idx - AW'(1);
                    end
                end
            end
            M_REV: nxt_idx = (idx == '0) ? last_q : idx - AW'(1);
            default: nxt_idx = idx;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state  <= S_IDLE;
            mode_q <= M_LOOP;
            last_q <= '0;
            presc  <= '0;
            dir    <= 1'b0;
            idx    <= '0;
            led    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else if (stop) begin
            // Stop wins over a simultaneous start; in IDLE this is a no-op.
            state <= S_IDLE;
            presc <= '0;
            dir   <= 1'b0;
            idx   <= '0;
            led   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else if (start && state != S_RUN) begin
            state  <= S_RUN;
            mode_q <= mode;
            last_q <= last_clamp;
            presc  <= '0;
            dir    <= (mode == M_REV);
            idx    <= (mode == M_REV) ? last_clamp : '0;
            led    <= '0;
            busy   <= 1'b1;
            done   <= 1'b0;
        end else if (state == S_RUN) begin
            led <= mem[idx];
            if (!hold) begin
                if (presc == PRESC_MAX) begin
                    presc <= '0;
                    if (finish) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        idx <= nxt_idx;
                        dir <= nxt_dir;
                    end
                end else begin
                    presc <= presc + PW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_led_pattern_player.sv
// Directed bench for led_pattern_player with TICK_DIV=2, DEPTH=8, WIDTH=8.
module tb_led_pattern_player;

    logic       clk;
    logic       resetn;
    logic       start;
    logic       stop;
    logic       hold;
    logic [1:0] mode;
    logic [2:0] last_idx;
    logic       wr_en;
    logic [2:0] wr_addr;
    logic [7:0] wr_data;
    logic [7:0] led;
    logic [2:0] idx;
    logic       busy;
    logic       done;

    int tests = 0;
    int fails = 0;
    int big   = 15;

    localparam logic [7:0] LOOP_LED [9] = '{8'h01, 8'h01, 8'h02, 8'h02, 8'h04, 8'h04, 8'h08, 8'h08, 8'h01};
    localparam logic [2:0] PP_IDX   [7] = '{3'd1, 3'd2, 3'd3, 3'd2, 3'd1, 3'd0, 3'd1};
    localparam logic [2:0] REV_IDX  [4] = '{3'd2, 3'd1, 3'd0, 3'd3};

    led_pattern_player #(.WIDTH(8), .DEPTH(8), .TICK_DIV(2)) dut (
        .clk(clk), .resetn(resetn), .start(start), .stop(stop), .hold(hold),
        .mode(mode), .last_idx(last_idx), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .led(led), .idx(idx), .busy(busy), .done(done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        step();
        wr_en = 1'b0;
    endtask

    task automatic go(input logic [1:0] m, input logic [2:0] l);
        mode = m; last_idx = l; start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic halt();
        stop = 1'b1;
        step();
        stop = 1'b0;
    endtask

    initial begin
        resetn = 1'b0; start = 1'b0; stop = 1'b0; hold = 1'b0;
        mode = 2'd0; last_idx = 3'd0; wr_en = 1'b0; wr_addr = 3'd0; wr_data = 8'h00;

        #2;
        chk("rst_led", led, 0);
        chk("rst_idx", idx, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        step();
        resetn = 1'b1;
        step(); step();
        chk("post_rst_idle_busy", busy, 0);
        chk("post_rst_idle_led", led, 0);

        wr(3'd0, 8'h01); wr(3'd1, 8'h02); wr(3'd2, 8'h04); wr(3'd3, 8'h08);
        wr(3'd4, 8'h10); wr(3'd5, 8'h20); wr(3'd6, 8'h40); wr(3'd7, 8'h80);

        // loop mode
        go(2'd0, 3'd3);
        chk("loop_busy", busy, 1);
        chk("loop_entry_led", led, 0);
        for (int i = 0; i < 9; i++) begin
            step();
            chk($sformatf("loop_led%0d", i), led, LOOP_LED[i]);
        end
        halt();
        chk("stop_busy", busy, 0);
        chk("stop_led", led, 0);
        chk("stop_idx", idx, 0);

        // one-shot mode
        go(2'd1, 3'd3);
        for (int i = 0; i < 8; i++) begin
            step();
            chk($sformatf("one_led%0d", i), led, LOOP_LED[i]);
        end
        chk("one_done", done, 1);
        chk("one_busy", busy, 0);
        chk("one_idx", idx, 3);
        step(); step(); step();
        chk("one_hold_led", led, 8'h08);
        chk("one_hold_done", done, 1);
        go(2'd1, 3'd3);
        step();
        chk("one_restart_led", led, 8'h01);
        chk("one_restart_busy", busy, 1);
        chk("one_restart_done", done, 0);
        halt();

        // ping-pong; a start pulse mid-run must be ignored
        go(2'd2, 3'd3);
        chk("pp_idx_init", idx, 0);
        for (int i = 0; i < 7; i++) begin
            if (i == 2) begin
                start = 1'b1; mode = 2'd0; last_idx = 3'd1;
            end
            step();
            start = 1'b0; mode = 2'd2; last_idx = 3'd3;
            step();
            chk($sformatf("pp_idx%0d", i), idx, PP_IDX[i]);
        end
        halt();
        go(2'd2, 3'd0);
        repeat (5) step();
        chk("pp0_idx", idx, 0);
        chk("pp0_led", led, 8'h01);
        chk("pp0_busy", busy, 1);
        halt();

        // reverse loop
        go(2'd3, 3'd3);
        chk("rev_idx_init", idx, 3);
        for (int i = 0; i < 4; i++) begin
            step(); step();
            chk($sformatf("rev_idx%0d", i), idx, REV_IDX[i]);
        end
        halt();
        go(2'd3, big[2:0]);
        chk("clamp_idx", idx, 7);
        step();
        chk("clamp_led", led, 8'h80);
        halt();

        // hold freezes idx and prescaler phase
        go(2'd0, 3'd3);
        step();
        chk("hold_pre_idx", idx, 0);
        hold = 1'b1;
        repeat (10) step();
        chk("hold_idx", idx, 0);
        chk("hold_led", led, 8'h01);
        hold = 1'b0;
        step();
        chk("hold_resume_idx_a", idx, 1);
        step();
        chk("hold_resume_idx_b", idx, 1);
        step();
        chk("hold_resume_idx_c", idx, 2);

        stop = 1'b1; start = 1'b1;
        step();
        stop = 1'b0; start = 1'b0;
        chk("stopstart_busy", busy, 0);
        chk("stopstart_led", led, 0);
        chk("stopstart_idx", idx, 0);
        step();
        chk("stopstart_stays_idle", busy, 0);

        // write to the displayed address while running
        go(2'd0, 3'd3);
        step();
        hold = 1'b1;
        wr(3'd0, 8'hAA);
        chk("wr_same_cycle_old", led, 8'h01);
        step();
        chk("wr_next_cycle_new", led, 8'hAA);
        hold = 1'b0;
        step();

        // asynchronous reset mid-run
        chk("pre_reset_busy", busy, 1);
        #2;
        resetn = 1'b0;
        #1;
        chk("async_rst_led", led, 0);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_idx", idx, 0);
        #2;
        resetn = 1'b1;
        repeat (3) step();
        chk("after_rst_busy", busy, 0);
        chk("after_rst_led", led, 0);
        chk("after_rst_done", done, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
